// File: rtl/adat_pkg.sv
// Shared types for the ADAT transmit path: sample/frame layout and scheduler states.
package adat_pkg;

  localparam int ADAT_CHANNELS = 8;
  localparam int ADAT_SAMPLE_W = 24;

  typedef logic signed [ADAT_SAMPLE_W-1:0] adat_sample_t;
  typedef adat_sample_t [0:ADAT_CHANNELS-1] adat_frame_t;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    FILL       = 2'd1,
    FULL       = 2'd2
  } adat_sched_state_t;

endpackage

// File: rtl/adat_tx_scheduler_if.sv
// Mixer sample stream plus serializer frame hand-off, bundled for adat_tx_scheduler.
interface adat_tx_scheduler_if;
  import adat_pkg::*;

  // Handshake: a sample transfers on a posedge where s_valid & s_ready; the mixer holds
  // s_sample/s_first stable while s_valid is high and s_ready is low. The serializer
  // samples audio_bus and the user bits on the posedge where data_request is high.
  adat_sample_t s_sample;
  logic         s_first;
  logic         s_valid;
  logic         s_ready;
  logic         timecode_in;
  logic         midi_in;
  logic         smux_in;
  logic         data_request;
  adat_frame_t  audio_bus;
  logic         timecode;
  logic         midi;
  logic         smux;

  modport master (
    output s_sample, s_first, s_valid, timecode_in, midi_in, smux_in, data_request,
    input  s_ready, audio_bus, timecode, midi, smux
  );

  modport slave (
    input  s_sample, s_first, s_valid, timecode_in, midi_in, smux_in, data_request,
    output s_ready, audio_bus, timecode, midi, smux
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; never wraps past all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/adat_tx_scheduler.sv
// Collects ch0..ch7 samples into a fill buffer and hands whole frames to the ADAT serializer.
// Build option ADAT_HOLD_ON_UNDERRUN_EN: an underrun swap repeats the last good frame.
module adat_tx_scheduler
  import adat_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MUTE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  adat_tx_scheduler_if.slave   bus,
  output logic                 underrun,
  output logic [CNT_W-1:0]     underrun_count,
  output logic [CNT_W-1:0]     resync_count,
  output adat_sched_state_t    state
);

  localparam int MUTE_W = $clog2(MUTE_FRAMES + 2);

  adat_sched_state_t state_q, state_fill, state_nx;
  logic [2:0]        count_q, count_nx;
  adat_frame_t       fill_q, fill_nx;
  adat_frame_t       audio_q;
  logic [MUTE_W-1:0] mute_q;
  logic              timecode_q, midi_q, smux_q;
  logic              underrun_q;
  logic              accept, frame_ok, resync_inc, underrun_inc;

  assign accept = bus.s_valid && (state_q != FULL);

  // Sample acceptance is applied first so a ch7 arriving on the swap edge completes the frame.
  always_comb begin
    fill_nx    = fill_q;
    count_nx   = count_q;
    state_fill = state_q;
    resync_inc = 1'b0;
    if (accept) begin
      if (bus.s_first) begin
        fill_nx[0] = bus.s_sample;
        count_nx   = 3'd1;
        state_fill = FILL;
        resync_inc = (state_q == FILL);
      end else if (state_q == WAIT_FIRST) begin
        resync_inc = 1'b1;
      end else begin
        fill_nx[count_q] = bus.s_sample;
        count_nx         = count_q + 3'd1;
        if (count_q == 3'd7) state_fill = FULL;
      end
    end
    frame_ok     = bus.data_request && (state_fill == FULL);
    underrun_inc = bus.data_request && !frame_ok;
    state_nx     = state_fill;
    if (frame_ok) begin
      state_nx = WAIT_FIRST;
      count_nx = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_FIRST;
      count_q    <= 3'd0;
      fill_q     <= '0;
      audio_q    <= '0;
      mute_q     <= MUTE_W'(MUTE_FRAMES);
      timecode_q <= 1'b0;
      midi_q     <= 1'b0;
      smux_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_nx;
      count_q    <= count_nx;
      fill_q     <= fill_nx;
      underrun_q <= underrun_inc;
      if (bus.data_request) begin
        timecode_q <= bus.timecode_in;
        midi_q     <= bus.midi_in;
        smux_q     <= bus.smux_in;
        if (mute_q != '0) begin
          audio_q <= '0;
          mute_q  <= mute_q - MUTE_W'(1);
        end else if (frame_ok) begin
          audio_q <= fill_nx;
        end else begin
`ifdef ADAT_HOLD_ON_UNDERRUN_EN
          audio_q <= audio_q;
`else
          audio_q <= '0;
`endif
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_underrun_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (underrun_inc),
    .clear (1'b0),
    .count (underrun_count)
  );

  sat_counter #(.W(CNT_W)) u_resync_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (resync_inc),
    .clear (1'b0),
    .count (resync_count)
  );

  assign bus.s_ready   = (state_q != FULL);
  assign bus.audio_bus = audio_q;
  assign bus.timecode  = timecode_q;
  assign bus.midi      = midi_q;
  assign bus.smux      = smux_q;
  assign underrun      = underrun_q;
  assign state         = state_q;

endmodule

// File: tb/tb_adat_tx_scheduler.sv
// Directed bench for adat_tx_scheduler: frames expected at each swap are queued when driven.
module tb_adat_tx_scheduler;
  import adat_pkg::*;

  localparam int CNT_W       = 16;
  localparam int MUTE_FRAMES = 4;
  localparam int FW          = 192;

  logic              clk;
  logic              rst;
  logic              underrun;
  logic [CNT_W-1:0]  underrun_count;
  logic [CNT_W-1:0]  resync_count;
  adat_sched_state_t state_dbg;

  adat_tx_scheduler_if bus ();

  adat_tx_scheduler #(.CNT_W(CNT_W), .MUTE_FRAMES(MUTE_FRAMES)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .resync_count   (resync_count),
    .state          (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int exp_ur_cnt = 0;
  logic [FW-1:0] exp_q[$];
  adat_frame_t   last_good;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present one sample and wait (bounded) for acceptance
  task automatic send(input logic [23:0] smp, input logic first);
    bit done;
    done = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_sample = smp;
    bus.s_first  = first;
    for (int k = 0; k < 600 && !done; k++) begin
      if (bus.s_ready) done = 1'b1;
      cycle();
    end
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    check("send_accept", FW'(done), FW'(1));
  endtask

  task automatic push_frame(input adat_frame_t f);
    exp_q.push_back(FW'(f));
  endtask

  // driver + scoreboard: one data_request edge, then compare against the queued frame
  task automatic swap_check(input string tag, input bit exp_ur);
    logic          tc, md, sx;
    logic [FW-1:0] exp_f;
    tc = 1'($urandom_range(0, 1));
    md = 1'($urandom_range(0, 1));
    sx = 1'($urandom_range(0, 1));
    bus.timecode_in  = tc;
    bus.midi_in      = md;
    bus.smux_in      = sx;
    bus.data_request = 1'b1;
    cycle();
    bus.data_request = 1'b0;
    bus.s_valid      = 1'b0;
    bus.s_first      = 1'b0;
    if (exp_ur) exp_ur_cnt++;
    exp_f = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, "_audio"}, FW'(bus.audio_bus), exp_f);
    check({tag, "_underrun"}, FW'(underrun), FW'(exp_ur));
    check({tag, "_ur_count"}, FW'(underrun_count), FW'(exp_ur_cnt));
    check({tag, "_userbits"}, FW'({bus.timecode, bus.midi, bus.smux}), FW'({tc, md, sx}));
    cycle();
    check({tag, "_underrun_clr"}, FW'(underrun), FW'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    adat_frame_t f;
    last_good        = '0;
    rst              = 1'b1;
    bus.s_sample     = '0;
    bus.s_first      = 1'b0;
    bus.s_valid      = 1'b0;
    bus.timecode_in  = 1'b1;
    bus.midi_in      = 1'b1;
    bus.smux_in      = 1'b1;
    bus.data_request = 1'b1;  // held high by a resetting serializer; must be ignored
    repeat (3) cycle();
    check("rst_audio", FW'(bus.audio_bus), FW'(0));
    check("rst_userbits", FW'({bus.timecode, bus.midi, bus.smux}), FW'(0));
    check("rst_underrun", FW'(underrun), FW'(0));
    check("rst_ur_count", FW'(underrun_count), FW'(0));
    check("rst_rs_count", FW'(resync_count), FW'(0));
    check("rst_state", FW'(state_dbg), FW'(WAIT_FIRST));
    check("rst_s_ready", FW'(bus.s_ready), FW'(1));
    rst              = 1'b0;
    bus.data_request = 1'b0;

    // idle frames, no samples: mute swaps and plain underruns all count
    for (int k = 0; k < MUTE_FRAMES + 1; k++) begin
      repeat (254) cycle();
      push_frame('0);
      swap_check("idle", 1'b1);
    end

    // complete frame well before the swap edge
    for (int c = 0; c < 8; c++) send(24'(c + 1), c == 0);
    check("full_s_ready", FW'(bus.s_ready), FW'(0));
    check("full_state", FW'(state_dbg), FW'(FULL));
    repeat (3) cycle();
    check("full_hold_s_ready", FW'(bus.s_ready), FW'(0));
    for (int c = 0; c < 8; c++) f[c] = 24'(c + 1);
    push_frame(f);
    last_good = f;
    swap_check("frame_a", 1'b0);
    check("after_swap_state", FW'(state_dbg), FW'(WAIT_FIRST));

    // ch7 arrives on the swap edge itself
    for (int c = 0; c < 7; c++) send(24'h000100 + 24'(c), c == 0);
    for (int c = 0; c < 7; c++) f[c] = 24'h000100 + 24'(c);
    f[7] = 24'h000008;
    push_frame(f);
    last_good    = f;
    bus.s_valid  = 1'b1;
    bus.s_first  = 1'b0;
    bus.s_sample = 24'h000008;
    swap_check("bypass", 1'b0);
    check("bypass_ch7", FW'(bus.audio_bus[7]), FW'(24'h000008));

    // misaligned s_first restarts the frame
    for (int c = 0; c < 4; c++) send(24'h0000A0 + 24'(c), c == 0);
    send(24'h7FFFFF, 1'b1);
    for (int c = 1; c < 8; c++) send(24'h0000B0 + 24'(c), 1'b0);
    check("resync_count_1", FW'(resync_count), FW'(1));
    f[0] = 24'h7FFFFF;
    for (int c = 1; c < 8; c++) f[c] = 24'h0000B0 + 24'(c);
    push_frame(f);
    last_good = f;
    swap_check("resync", 1'b0);

    // stray sample in WAIT_FIRST is dropped
    send(24'h123456, 1'b0);
    check("stray_resync", FW'(resync_count), FW'(2));
    check("stray_state", FW'(state_dbg), FW'(WAIT_FIRST));

    // partial frame at the swap, completed by the next one
    for (int c = 0; c < 5; c++) send(24'h0000C0 + 24'(c), c == 0);
`ifdef ADAT_HOLD_ON_UNDERRUN_EN
    push_frame(last_good);
`else
    push_frame('0);
`endif
    swap_check("partial", 1'b1);
    check("partial_state", FW'(state_dbg), FW'(FILL));
    send(24'h8000C5, 1'b0);
    send(24'hFFFFFF, 1'b0);
    send(24'h0000C7, 1'b0);
    for (int c = 0; c < 5; c++) f[c] = 24'h0000C0 + 24'(c);
    f[5] = 24'h8000C5;
    f[6] = 24'hFFFFFF;
    f[7] = 24'h0000C7;
    push_frame(f);
    last_good = f;
    swap_check("partial_done", 1'b0);

    // reset in the middle of a fill, with data_request asserted
    for (int c = 0; c < 5; c++) send(24'h0000D0 + 24'(c), c == 0);
    rst              = 1'b1;
    bus.data_request = 1'b1;
    cycle();
    check("mid_rst_audio", FW'(bus.audio_bus), FW'(0));
    check("mid_rst_userbits", FW'({bus.timecode, bus.midi, bus.smux}), FW'(0));
    check("mid_rst_underrun", FW'(underrun), FW'(0));
    check("mid_rst_ur_count", FW'(underrun_count), FW'(0));
    check("mid_rst_rs_count", FW'(resync_count), FW'(0));
    check("mid_rst_state", FW'(state_dbg), FW'(WAIT_FIRST));
    rst              = 1'b0;
    bus.data_request = 1'b0;
    exp_ur_cnt       = 0;
    send(24'h000055, 1'b0);
    check("post_rst_needs_first", FW'(resync_count), FW'(1));

    // mute period restarted by reset: complete frame discarded, empty swap still an underrun
    for (int c = 0; c < 8; c++) send(24'h0000E0 + 24'(c), c == 0);
    push_frame('0);
    swap_check("mute_discard", 1'b0);
    check("mute_discard_state", FW'(state_dbg), FW'(WAIT_FIRST));
    push_frame('0);
    swap_check("mute_underrun", 1'b1);

    check("queue_empty", FW'(exp_q.size()), FW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
